// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for the execute stage: a fixed-latency multiply or a
// 32-step restoring divide, holding the pipeline with stall_req until a single HI/LO write pulse.
module hilo_muldiv_ctrl #(
   parameter int MUL_LAT = 2,
   parameter int WIDTH   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             ismultE,
   input  logic             signedmultE,
   input  logic             isdivE,
   input  logic             signeddivE,
   input  logic [WIDTH-1:0] srcaE,
   input  logic [WIDTH-1:0] srcbE,
   output logic             stall_req,
   output logic             busy,
   output logic             hilo_we,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             div_zero
);

   localparam int CNT_W = 6;

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   a_q, a_d;      // multiplicand, or dividend magnitude shifting into the quotient
   logic [WIDTH-1:0]   b_q, b_d;      // multiplier, or divisor magnitude
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               sgn_q, sgn_d;
   logic               negq_q, negq_d;
   logic               negr_q, negr_d;
   logic               dz_q, dz_d;

   logic               start;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] a_ext, b_ext, prod;
   logic [WIDTH:0]     shifted, trial;
   logic [WIDTH-1:0]   step_rem, step_quo;

   assign start = (ismultE | isdivE) & ~flush;
   assign a_neg = signeddivE & srcaE[WIDTH-1];
   assign b_neg = signeddivE & srcbE[WIDTH-1];
   assign a_mag = a_neg ? -srcaE : srcaE;
   assign b_mag = b_neg ? -srcbE : srcbE;

   // Low 2*WIDTH bits of the extended product are exact for both signed and unsigned operands.
   assign a_ext = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
   assign b_ext = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
   assign prod  = a_ext * b_ext;

   // One restoring step: bring in the next dividend bit and subtract the divisor if it fits.
   assign shifted  = {rem_q, a_q[WIDTH-1]};
   assign trial    = shifted - {1'b0, b_q};
   assign step_rem = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
   assign step_quo = {a_q[WIDTH-2:0], ~trial[WIDTH]};

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
      state_d   = state_q;
      cnt_d     = cnt_q;
      a_d       = a_q;
      b_d       = b_q;
      rem_d     = rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      sgn_d     = sgn_q;
      negq_d    = negq_q;
      negr_d    = negr_q;
      dz_d      = dz_q;
      stall_req = 1'b0;
      hilo_we   = 1'b0;
      div_zero  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               stall_req = 1'b1;
               cnt_d     = '0;
               dz_d      = 1'b0;
               if (ismultE) begin
                  state_d = MUL;
                  a_d     = srcaE;
                  b_d     = srcbE;
                  sgn_d   = signedmultE;
               end else if (srcbE == '0) begin
                  state_d = DONE;
                  hi_d    = srcaE;
                  lo_d    = '1;
                  dz_d    = 1'b1;
               end else begin
                  state_d = DIV;
                  a_d     = a_mag;
                  b_d     = b_mag;
                  rem_d   = '0;
                  negq_d  = a_neg ^ b_neg;
                  negr_d  = a_neg;
               end
            end
         end
         MUL: begin
            stall_req = 1'b1;
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
               state_d = DONE;
               hi_d    = prod[2*WIDTH-1:WIDTH];
               lo_d    = prod[WIDTH-1:0];
            end
         end
         DIV: begin
            stall_req = 1'b1;
            cnt_d     = cnt_q + CNT_W'(1);
            rem_d     = step_rem;
            a_d       = step_quo;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = DONE;
               hi_d    = negr_q ? -step_rem : step_rem;
               lo_d    = negq_q ? -step_quo : step_quo;
            end
         end
         DONE: begin
            hilo_we  = 1'b1;
            div_zero = dz_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (flush) begin
         stall_req = 1'b0;
         hilo_we   = 1'b0;
         div_zero  = 1'b0;
         state_d   = IDLE;
         hi_d      = hi_q;
         lo_d      = lo_q;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         sgn_q   <= 1'b0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         sgn_q   <= sgn_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         dz_q    <= dz_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign hi_out = hi_q;
   assign lo_out = lo_q;

endmodule
